// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding a single FIFO write port.
// Build option: define FIFO_ARB_PRIO_EN to let requester 0 win every arbitration it enters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  localparam int ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_wrdata,
  output logic                          fifo_wren,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          dbg_state
);

  // Handshake: a word moves on a rising edge where req_valid[i] and req_ready[i]
  // are both high; ready is only ever offered to the current grantee.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e                  state_q;
  logic [ID_W-1:0]         grant_id_q;
  logic [ID_W-1:0]         last_grant_q;
  logic [7:0]              burst_cnt_q;
  logic                    fifo_wren_q;
  logic [DATA_WIDTH-1:0]   fifo_wrdata_q;
  logic [ID_W-1:0]         pick;
  logic [ID_W-1:0]         idx;
  logic                    space_ok;
  logic                    xfer;
  logic [DATA_WIDTH-1:0]   req_word [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    pick = last_grant_q;
    idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (req_valid[idx]) pick = idx;
    end
`ifdef FIFO_ARB_PRIO_EN
    if (req_valid[0]) pick = '0;
`else
`endif
  end

  // The word already sitting in the output register consumes the last free entry.
  assign space_ok = !fifo_full && !(fifo_almost_full && fifo_wren_q);
  assign xfer     = (state_q == GRANT) && req_valid[grant_id_q] && space_ok;

  always_comb begin
    req_ready = '0;
    if (state_q == GRANT && space_ok) req_ready[grant_id_q] = req_valid[grant_id_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      burst_cnt_q   <= '0;
      fifo_wren_q   <= 1'b0;
      fifo_wrdata_q <= '0;
    end else begin
      fifo_wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_id_q  <= pick;
            burst_cnt_q <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            fifo_wren_q   <= 1'b1;
            fifo_wrdata_q <= req_word[grant_id_q];
            burst_cnt_q   <= burst_cnt_q + 8'd1;
            if (burst_cnt_q + 8'd1 == MAX_BURST[7:0]) begin
              state_q      <= IDLE;
              last_grant_q <= grant_id_q;
            end
          end else if (!req_valid[grant_id_q]) begin
            state_q      <= IDLE;
            last_grant_q <= grant_id_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wren   = fifo_wren_q;
  assign fifo_wrdata = fifo_wrdata_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q == GRANT);
  assign dbg_state   = state_q;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 32: word width, equal to the downstream FIFO width.
REQ-003 Parameter MAX_BURST, default 8: maximum words per grant, range 1..255.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester word valid.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 fifo_wrdata  output  DATA_WIDTH  registered write data to the FIFO.
REQ-010 fifo_wren  output  1  registered write enable to the FIFO.
REQ-011 fifo_full  input  1  FIFO full flag.
REQ-012 fifo_almost_full  input  1  FIFO has exactly one free entry.
REQ-013 grant_id  output  max(1,$clog2(NUM_REQ))  index of the current grantee; held at the last grantee in IDLE.
REQ-014 busy  output  1  high in GRANT state.

Function
REQ-015 FSM states: IDLE and GRANT.
REQ-016 IDLE: if any req_valid is high, select the first valid requester searching round-robin from (last_grant+1) mod NUM_REQ; load grant_id, clear burst_cnt, and enter GRANT on the next edge.
REQ-017 Arbitration latency: exactly 1 cycle from valid in IDLE to busy high; req_ready is always 0 in IDLE.
REQ-018 Space check: space_ok = !fifo_full && !(fifo_almost_full && fifo_wren), which accounts for the word already in the output register.
REQ-019 GRANT: req_ready[grant_id] = req_valid[grant_id] && space_ok (combinational); all other ready bits are 0.
REQ-020 Transfer: when req_valid and req_ready are both high, the next edge sets fifo_wren=1 and fifo_wrdata=the grantee's data, and increments burst_cnt; otherwise fifo_wren=0 and fifo_wrdata holds its value.
REQ-021 GRANT exits to IDLE, with last_grant<=grant_id, when a transfer makes burst_cnt reach MAX_BURST.
REQ-022 GRANT also exits to IDLE when req_valid[grant_id] is low.
REQ-023 Backpressure (space_ok=0) does not end a grant; the burst resumes when space returns.
REQ-024 fifo_wren is never asserted while fifo_full was high at the accepting edge, so no FIFO overrun occurs under any sequence.
REQ-025 Back-to-back grants: minimum 1 idle cycle between bursts, to allow arbitration.
REQ-026 Wrap-around: the round-robin pointer wraps from NUM_REQ-1 to 0.
REQ-027 Changes in a non-grantee's valid during GRANT have no effect until the next IDLE.

Reset
REQ-028 On reset: state=IDLE, fifo_wren=0, fifo_wrdata=0, last_grant=NUM_REQ-1 (so requester 0 is first), grant_id=0, burst_cnt=0, busy=0, req_ready=0.
REQ-029 Reset asserted mid-burst aborts the burst; a word captured at that edge is discarded (fifo_wren=0).

Configuration
REQ-030 Macro FIFO_ARB_PRIO_EN defined: in IDLE, requester 0 wins whenever req_valid[0] is high, overriding round-robin; MAX_BURST still applies; last_grant updates normally.
REQ-031 FIFO_ARB_PRIO_EN undefined: pure round-robin, with no requester favoured.

Verification
REQ-032 Single requester: reset, then req_valid=4'b0010 with 3 words -> busy at cycle 1, fifo_wren pulses 3 consecutive cycles with data in order, then IDLE.
REQ-033 All valid continuously, MAX_BURST=8 -> grants 0,1,2,3,0 in that order, each exactly 8 writes, 1 gap cycle between bursts.
REQ-034 Full FIFO: fifo_almost_full=1 while a write is pending -> req_ready=0; fifo_full=1 for 5 cycles -> no fifo_wren; burst completes after release with no lost or duplicated word.
REQ-035 Reset during a burst at word 4 of 8 -> next cycle fifo_wren=0, state IDLE, next grant goes to requester 0.
REQ-036 With FIFO_ARB_PRIO_EN, valid=4'b1111 -> requester 0 is granted after every burst; without the macro -> rotation as in REQ-033.
REQ-037 Grantee valid drops after 2 words (MAX_BURST=8) -> exit to IDLE; next grant is (grantee+1) mod 4.
